// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the shared regfile write port, with a per-bank pending-write
// scoreboard that the issue stage uses to detect RAW/WAW hazards.
module regfile_wb_arbiter #(
  parameter int WIDTH  = 16,
  parameter int REGS   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              v_valid,
  output logic              v_ready,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [WIDTH-1:0]  v_data,
  input  logic              v_esc,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rsv_vec,
  output logic              rsv_ready,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  input  logic              q_vec,
  output logic              q_busy1,
  output logic              q_busy2,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [WIDTH-1:0]  wd3,
  output logic              isvector,
  output logic              vect_esc,
  output logic              pc_write_err
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);
  localparam logic [REGS-1:0]   ONE     = REGS'(1);

  logic              r_last_v;
  logic [REGS-1:0]   r_pend_s;
  logic [REGS-1:0]   r_pend_v;
  logic              r_we3;
  logic [ADDR_W-1:0] r_wa3;
  logic [WIDTH-1:0]  r_wd3;
  logic              r_isvec;
  logic              r_esc;
  logic              r_pc_err;

  logic              w_s_gnt;
  logic              w_v_gnt;
  logic              w_rsv_ok;
  logic [REGS-1:0]   w_set_s;
  logic [REGS-1:0]   w_set_v;
  logic [REGS-1:0]   w_clr_s;
  logic [REGS-1:0]   w_clr_v;

  // Grants are masked during reset so nothing is consumed that will be squashed.
  assign w_s_gnt  = rst_n && s_valid && (!v_valid || r_last_v);
  assign w_v_gnt  = rst_n && v_valid && (!s_valid || !r_last_v);
  assign w_rsv_ok = rst_n && !(rsv_vec ? r_pend_v[rsv_addr] : r_pend_s[rsv_addr]);

  assign s_ready   = w_s_gnt;
  assign v_ready   = w_v_gnt;
  assign rsv_ready = w_rsv_ok;
  assign q_busy1   = q_vec ? r_pend_v[q_addr1] : r_pend_s[q_addr1];
  assign q_busy2   = q_vec ? r_pend_v[q_addr2] : r_pend_s[q_addr2];

  // The write presented this cycle commits at the coming edge, so its pending bit drops then.
  assign w_clr_s = (r_we3 && !r_isvec) ? (ONE << r_wa3) : '0;
  assign w_clr_v = (r_we3 &&  r_isvec) ? (ONE << r_wa3) : '0;
  assign w_set_s = (rsv_valid && w_rsv_ok && !rsv_vec) ? (ONE << rsv_addr) : '0;
  assign w_set_v = (rsv_valid && w_rsv_ok &&  rsv_vec) ? (ONE << rsv_addr) : '0;

  assign we3          = r_we3;
  assign wa3          = r_wa3;
  assign wd3          = r_wd3;
  assign isvector     = r_isvec;
  assign vect_esc     = r_esc;
  assign pc_write_err = r_pc_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_v <= 1'b1;
      r_pend_s <= '0;
      r_pend_v <= '0;
      r_we3    <= 1'b0;
      r_wa3    <= '0;
      r_wd3    <= '0;
      r_isvec  <= 1'b0;
      r_esc    <= 1'b0;
      r_pc_err <= 1'b0;
    end else begin
      r_pend_s <= (r_pend_s & ~w_clr_s) | w_set_s;
      r_pend_v <= (r_pend_v & ~w_clr_v) | w_set_v;
      r_we3    <= 1'b0;
      r_pc_err <= 1'b0;
      if (w_s_gnt) begin
        r_last_v <= 1'b0;
        // Scalar R15 is the PC: the request is consumed but never reaches the regfile.
        if (s_addr == PC_ADDR) begin
          r_pc_err <= 1'b1;
        end else begin
          r_we3   <= 1'b1;
          r_wa3   <= s_addr;
          r_wd3   <= s_data;
          r_isvec <= 1'b0;
          r_esc   <= 1'b0;
        end
      end else if (w_v_gnt) begin
        r_last_v <= 1'b1;
        r_we3    <= 1'b1;
        r_wa3    <= v_addr;
        r_wd3    <= v_data;
        r_isvec  <= 1'b1;
        r_esc    <= v_esc;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a bank/array model predicts every output each cycle,
// and literal expectations at key points pin the model itself.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, v_valid, v_esc, rsv_valid, rsv_vec, q_vec;
  logic [3:0]  s_addr, v_addr, rsv_addr, q_addr1, q_addr2;
  logic [15:0] s_data, v_data;
  logic        s_ready, v_ready, rsv_ready, q_busy1, q_busy2;
  logic        we3, isvector, vect_esc, pc_write_err;
  logic [3:0]  wa3;
  logic [15:0] wd3;

  regfile_wb_arbiter #(.WIDTH(16), .REGS(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .v_valid(v_valid), .v_ready(v_ready), .v_addr(v_addr), .v_data(v_data), .v_esc(v_esc),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_vec(rsv_vec), .rsv_ready(rsv_ready),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_vec(q_vec), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .we3(we3), .wa3(wa3), .wd3(wd3), .isvector(isvector), .vect_esc(vect_esc),
    .pc_write_err(pc_write_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who won last, which registers are waiting for a write, what the write port shows.
  localparam int SCALAR = 0, VECTOR = 1;
  bit          model_ok = 0;
  int          m_last;
  bit          m_pend [2][16];
  logic [15:0] m_rf   [2][16];
  bit          m_we3, m_isv, m_esc, m_pc;
  logic [3:0]  m_wa3;
  logic [15:0] m_wd3;

  function automatic bit exp_s_gnt();
    if (!rst_n || !s_valid) return 0;
    return !v_valid || (m_last == VECTOR);
  endfunction

  function automatic bit exp_v_gnt();
    if (!rst_n || !v_valid) return 0;
    return !s_valid || (m_last == SCALAR);
  endfunction

  function automatic bit exp_rsv_ok();
    return rst_n && !m_pend[rsv_vec][rsv_addr];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_pend[b, r]) m_pend[b][r] = 0;
      m_we3 = 0; m_wa3 = 0; m_wd3 = 0; m_isv = 0; m_esc = 0; m_pc = 0;
      m_last = VECTOR;
      model_ok = 1;
    end else if (model_ok) begin
      bit sg, vg, rok;
      sg  = exp_s_gnt();
      vg  = exp_v_gnt();
      rok = exp_rsv_ok();
      if (m_we3) begin
        m_rf[m_isv][m_wa3]   = m_wd3;
        m_pend[m_isv][m_wa3] = 0;
      end
      if (rsv_valid && rok) m_pend[rsv_vec][rsv_addr] = 1;
      m_we3 = 0;
      m_pc  = 0;
      if (sg) begin
        m_last = SCALAR;
        if (s_addr == 4'd15) m_pc = 1;
        else begin m_we3 = 1; m_wa3 = s_addr; m_wd3 = s_data; m_isv = 0; m_esc = 0; end
      end else if (vg) begin
        m_last = VECTOR;
        m_we3 = 1; m_wa3 = v_addr; m_wd3 = v_data; m_isv = 1; m_esc = v_esc;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("s_ready", s_ready, exp_s_gnt());
      chk("v_ready", v_ready, exp_v_gnt());
      chk("rsv_ready", rsv_ready, exp_rsv_ok());
      chk("q_busy1", q_busy1, m_pend[q_vec][q_addr1]);
      chk("q_busy2", q_busy2, m_pend[q_vec][q_addr2]);
      chk("we3", we3, m_we3);
      chk("pc_write_err", pc_write_err, m_pc);
      if (m_we3) begin
        chk("wa3", wa3, m_wa3);
        chk("wd3", wd3, m_wd3);
        chk("isvector", isvector, m_isv);
        chk("vect_esc", vect_esc, m_esc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 0;
    s_valid = 1; s_addr = 4'd1; s_data = 16'h0001;
    v_valid = 1; v_addr = 4'd2; v_data = 16'h0002; v_esc = 0;
    rsv_valid = 1; rsv_addr = 4'd0; rsv_vec = 0;
    q_addr1 = 0; q_addr2 = 0; q_vec = 0;

    // Reset held two cycles with every request asserted
    step(); step(); settle();
    chk("lit_rst_s_ready", s_ready, 0);
    chk("lit_rst_v_ready", v_ready, 0);
    chk("lit_rst_rsv_ready", rsv_ready, 0);
    chk("lit_rst_we3", we3, 0);

    // Release with both valid: scalar wins first; single scalar write R3 <= 9
    rst_n = 1; rsv_valid = 0;
    s_addr = 4'd3; s_data = 16'd9;
    v_addr = 4'd10; v_data = 16'h0055;
    settle();
    chk("lit_first_s_ready", s_ready, 1);
    chk("lit_first_v_ready", v_ready, 0);
    step(); s_valid = 0; settle();
    chk("lit_sw_v_ready", v_ready, 1);
    chk("lit_sw_we3", we3, 1);
    chk("lit_sw_wa3", wa3, 3);
    chk("lit_sw_wd3", wd3, 9);
    chk("lit_sw_isvector", isvector, 0);
    step(); v_valid = 0; settle();
    chk("lit_vw_wa3", wa3, 10);
    chk("lit_vw_isvector", isvector, 1);
    step(); settle();
    chk("lit_model_r3", m_rf[0][3], 9);
    chk("lit_idle_we3", we3, 0);

    // Scoreboard: reserve vector 4, WAW stall on repeat, scalar 4 stays free
    rsv_valid = 1; rsv_vec = 1; rsv_addr = 4'd4; settle();
    chk("lit_rsv_v4_ready", rsv_ready, 1);
    step(); q_vec = 1; q_addr1 = 4'd4; q_addr2 = 4'd5; settle();
    chk("lit_rsv_v4_again", rsv_ready, 0);
    chk("lit_qbusy_v4", q_busy1, 1);
    step(); rsv_valid = 0; rsv_vec = 0; q_vec = 0; settle();
    chk("lit_rsv_s4_free", rsv_ready, 1);
    chk("lit_qbusy_s4", q_busy1, 0);
    q_vec = 1;

    // Contention: S(6,5) V(4,8,esc) S(6,5) V(6,3)
    s_valid = 1; s_addr = 4'd6; s_data = 16'd5;
    v_valid = 1; v_addr = 4'd4; v_data = 16'd8; v_esc = 1; settle();
    chk("lit_ct1_s_ready", s_ready, 1);
    chk("lit_ct1_v_ready", v_ready, 0);
    step(); settle();
    chk("lit_ct2_v_ready", v_ready, 1);
    chk("lit_ct2_s_ready", s_ready, 0);
    chk("lit_ct2_wa3", wa3, 6);
    chk("lit_ct2_wd3", wd3, 5);
    step(); v_addr = 4'd6; v_data = 16'd3; v_esc = 0; settle();
    chk("lit_ct3_s_ready", s_ready, 1);
    chk("lit_ct3_wa3", wa3, 4);
    chk("lit_ct3_wd3", wd3, 8);
    chk("lit_ct3_isvector", isvector, 1);
    chk("lit_ct3_vect_esc", vect_esc, 1);
    chk("lit_ct3_qbusy_v4", q_busy1, 1);
    step(); settle();
    chk("lit_ct4_v_ready", v_ready, 1);
    chk("lit_ct4_qbusy_v4_clr", q_busy1, 0);
    chk("lit_ct4_isvector", isvector, 0);
    step(); s_valid = 0; v_valid = 0; settle();
    chk("lit_ct5_wa3", wa3, 6);
    chk("lit_ct5_wd3", wd3, 3);
    chk("lit_ct5_isvector", isvector, 1);
    step();

    // R15 protection: scalar write dropped with error pulse, vector 15 is legal
    s_valid = 1; s_addr = 4'd15; s_data = 16'h0004; settle();
    chk("lit_r15_s_ready", s_ready, 1);
    step(); s_valid = 0; v_valid = 1; v_addr = 4'd15; v_data = 16'h0077; settle();
    chk("lit_r15_we3", we3, 0);
    chk("lit_r15_err", pc_write_err, 1);
    step(); v_valid = 0; settle();
    chk("lit_r15_err_gone", pc_write_err, 0);
    chk("lit_v15_we3", we3, 1);
    chk("lit_v15_wa3", wa3, 15);
    step();

    // Write registered just before reset is still presented during the reset cycle
    s_valid = 1; s_addr = 4'd8; s_data = 16'h0011;
    step(); s_valid = 0; rst_n = 0; settle();
    chk("lit_prerst_we3", we3, 1);
    chk("lit_prerst_wa3", wa3, 8);
    step(); rst_n = 1; settle();
    chk("lit_postrst_we3", we3, 0);

    // Reset mid-operation: reservations discarded, grant in reset cycle squashed
    rsv_valid = 1; rsv_vec = 0; rsv_addr = 4'd2;
    step(); rsv_addr = 4'd5;
    step(); rsv_valid = 0; q_vec = 0; q_addr1 = 4'd2; q_addr2 = 4'd5; settle();
    chk("lit_mid_qbusy2", q_busy1, 1);
    chk("lit_mid_qbusy5", q_busy2, 1);
    s_valid = 1; s_addr = 4'd7; s_data = 16'h0033; rst_n = 0; settle();
    chk("lit_mid_s_ready", s_ready, 0);
    step(); s_valid = 0; rst_n = 1; settle();
    chk("lit_mid_we3", we3, 0);
    chk("lit_mid_qbusy2_clr", q_busy1, 0);
    chk("lit_mid_qbusy5_clr", q_busy2, 0);
    step(); settle();
    chk("lit_mid_we3_after", we3, 0);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and hazard scoreboard for the 16×16 scalar/vector register file (`regfile`). It shares the register file's single write port (`we3`/`wa3`/`wd3`/`isvector`/`vect_esc`) between the scalar ALU write-back path and the vector unit write-back path using round-robin arbitration. It also tracks pending destination registers so the issue stage can detect RAW and WAW hazards. It sits between the execute stages and `regfile`, and all outputs that drive `regfile` are registered.

## Interface
- `WIDTH`, 16, data width of `wd3`
- `REGS`, 16, registers per bank (scalar bank and vector bank)
- `ADDR_W`, 4, register address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `s_valid`  in  1  scalar write-back request
- `s_ready`  out  1  scalar request granted this cycle
- `s_addr`  in  ADDR_W  scalar destination register
- `s_data`  in  WIDTH  scalar write data
- `v_valid`  in  1  vector write-back request
- `v_ready`  out  1  vector request granted this cycle
- `v_addr`  in  ADDR_W  vector destination register
- `v_data`  in  WIDTH  vector write data
- `v_esc`  in  1  vector-scalar qualifier, forwarded to `vect_esc`
- `rsv_valid`  in  1  issue stage reserves a destination register
- `rsv_addr`  in  ADDR_W  register to reserve
- `rsv_vec`  in  1  1 = vector bank, 0 = scalar bank
- `rsv_ready`  out  1  reservation accepted (target not pending)
- `q_addr1`, `q_addr2`  in  ADDR_W  source operands queried for hazards
- `q_vec`  in  1  bank of the queried operands
- `q_busy1`, `q_busy2`  out  1  queried register has a pending write
- `we3`  out  1  register file write enable (registered)
- `wa3`  out  ADDR_W  register file write address (registered)
- `wd3`  out  WIDTH  register file write data (registered)
- `isvector`  out  1  write targets the vector bank (registered)
- `vect_esc`  out  1  forwarded vector-scalar qualifier (registered)
- `pc_write_err`  out  1  one-cycle pulse: illegal scalar write to R15

## Operation
- **Arbitration.** One write-back grant per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that was not granted most recently wins.
  - Priority pointer `last` is updated only on a grant. Its reset value is "vector", so the first contention goes to scalar.
- **Grant signals.**
  - `s_ready`/`v_ready` are combinational from the valid inputs and `last`. They are never asserted without the matching valid.
  - A requester holds `addr`/`data` stable while valid and not ready.
- **Write issue.** A grant in cycle N drives registered outputs in cycle N+1:
  - `we3`=1
  - `wa3`=addr, `wd3`=data
  - `isvector`=1 for a vector grant, 0 for scalar
  - `vect_esc`=`v_esc` for a vector grant, 0 for scalar
- **No grant.** `we3`=0. `wa3`/`wd3`/`isvector`/`vect_esc` hold their previous values.
- **R15 protection.** R15 of the scalar bank is the PC.
  - A scalar grant with `s_addr`=15 is consumed (`s_ready`=1) but produces `we3`=0 in N+1 and `pc_write_err`=1 in N+1.
  - Vector address 15 is legal.
- **Scoreboard state.** 2×REGS pending bits, one set per bank.
- **Reservation.**
  - `rsv_ready` = !pending[rsv_vec][rsv_addr], evaluated from current registered state.
  - `rsv_valid && rsv_ready` sets the bit at the clock edge.
  - `rsv_valid` with `rsv_ready`=0 is a WAW stall: no state change, and the issue stage retries.
- **Clear.**
  - The bit [`isvector`][`wa3`] is cleared at the edge ending the cycle in which registered `we3`=1.
  - At that edge `regfile` commits the data, so no stale-read window exists.
- **Unreserved writes.** A write to a non-pending register is legal; the clear is a no-op.
- **Simultaneous set and clear.**
  - Set and clear of different bits in one cycle: both take effect.
  - Same bit: impossible by construction, because `rsv_ready`=0 while the bit is set.
- **Hazard query.** `q_busy1`/`q_busy2` = pending[q_vec][q_addr*]. This is combinational from registered state.

## Timing
- Reset (`rst_n`=0 at an edge), applied after that edge:
  - all pending bits 0
  - `we3`=0, `wa3`=0, `wd3`=0, `isvector`=0, `vect_esc`=0, `pc_write_err`=0
  - `last`=vector
- Grants are still computed combinationally during reset, but they are not honoured: `s_ready`=`v_ready`=`rsv_ready`=0 while `rst_n`=0.
- Reset mid-operation:
  - A write registered in the cycle before reset is still presented for that one cycle.
  - Any grant in the reset cycle is squashed.
  - All reservations are discarded.
- Latency:
  - grant → `we3` = 1 cycle
  - grant → data visible on `regfile` read ports = 2 cycles
  - grant → `q_busy` deassert = 2 cycles
- Reservation → `q_busy`/`rsv_ready` reflect it from the next cycle.
- Throughput: 1 write per cycle sustained. Under continuous contention, grants strictly alternate S, V, S, V.

## Test plan
- **Reset defaults.** Hold `rst_n`=0 for 2 cycles with all valids=1.
  - Required: `s_ready`=`v_ready`=`rsv_ready`=0 and `we3`=0.
  - After release with both valid: first grant is scalar.
- **Single scalar write.** `s_valid` with `s_addr`=3, `s_data`=9.
  - Required: `s_ready`=1 in cycle N.
  - Cycle N+1: `we3`=1, `wa3`=3, `wd3`=9, `isvector`=0.
  - `regfile` R3 reads 9 from N+2.
- **Contention.** `s_valid`=`v_valid`=1 for 4 cycles: S(addr 6, 5), V(addr 4, 8, `v_esc`=1), S(addr 6, 5), V(addr 6, 3).
  - Required: grants alternate S, V, S, V.
  - `we3` sequence: 6/5/0, 4/8/1 (`isvector`=1, `vect_esc`=1), 6/5/0, 6/3/1.
- **Scoreboard.** Reserve vector 4, then query `q_vec`=1, `q_addr1`=4.
  - Required: `q_busy1`=1 and a second reservation of vector 4 gives `rsv_ready`=0.
  - Scalar 4 stays free.
  - After the V write to 4, `q_busy1`=0 two cycles after its grant.
- **R15 protection.** Scalar write to R15 with data 0x0004.
  - Required: `s_ready`=1, then `we3`=0 and `pc_write_err`=1 for exactly one cycle.
  - A vector write to 15 proceeds normally.
- **Reset mid-operation.** Reserve scalar 2 and 5, grant a write to scalar 7, and assert `rst_n`=0 in the grant cycle.
  - Required: no `we3` for the squashed grant.
  - All `q_busy` read 0 after reset.
